// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one period counter.
//
// Optional feature macro: PWM_MULTI_CENTER_EN
//   defined   -> edge- and center-aligned modes, selected by i_mode
//   undefined -> edge-aligned only; i_mode ignored, o_dir_down tied 0
//
// Ports
//   i_clk            sole clock, rising edge
//   i_rst            synchronous active-high reset
//   i_top            period top value (staged)
//   i_mode           0 = edge, 1 = center (staged together with i_top)
//   i_top_valid      write strobe for i_top / i_mode
//   i_compare        compare value, RESOLUTION+1 bits so that top+1 gives 100 %
//   i_compare_ch     channel addressed by the compare write
//   i_compare_valid  write strobe for i_compare
//   o_pwm            PWM outputs, bit n = channel n (combinational from flops)
//   o_cycle_end      one-cycle pulse in the first cycle of each new period
//   o_dir_down       counting direction, 1 = down (center mode only)
//
// Handshake: each *_valid is a single-cycle write strobe with no ready;
// a write is taken on every rising edge where the strobe is high and
// reset is low. Writes land in staging registers; active registers copy
// staging (including a write in the same cycle) only at a reload event.
module pwm_multi #(
  parameter int RESOLUTION = 8,
  parameter int CHANNELS   = 4,
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [RESOLUTION-1:0] i_top,
  input  logic                  i_mode,
  input  logic                  i_top_valid,
  input  logic [RESOLUTION:0]   i_compare,
  input  logic [CH_BITS-1:0]    i_compare_ch,
  input  logic                  i_compare_valid,
  output logic [CHANNELS-1:0]   o_pwm,
  output logic                  o_cycle_end,
  output logic                  o_dir_down
);

  logic [RESOLUTION-1:0] cnt_q, cnt_d;
  logic [RESOLUTION-1:0] top_stg_q, top_stg_d;
  logic [RESOLUTION-1:0] top_act_q, top_act_d;
  logic [RESOLUTION:0]   cmp_stg_q [CHANNELS];
  logic [RESOLUTION:0]   cmp_stg_d [CHANNELS];
  logic [RESOLUTION:0]   cmp_act_q [CHANNELS];
  logic [RESOLUTION:0]   cmp_act_d [CHANNELS];
  logic                  cyc_end_q, cyc_end_d;
  logic                  reload;

`ifdef PWM_MULTI_CENTER_EN
  typedef enum logic {ST_UP = 1'b0, ST_DOWN = 1'b1} state_t;
  state_t state_q, state_d;
  logic   mode_stg_q, mode_stg_d;
  logic   mode_act_q, mode_act_d;
`else
  logic   unused_mode;
  assign unused_mode = i_mode;
`endif

  always_comb begin
    top_stg_d = top_stg_q;
    top_act_d = top_act_q;
    cmp_stg_d = cmp_stg_q;
    cmp_act_d = cmp_act_q;
    cnt_d     = cnt_q;
    reload    = 1'b0;
    if (i_top_valid) top_stg_d = i_top;
    // Out-of-range channel numbers match no n and are dropped.
    for (int n = 0; n < CHANNELS; n++) begin
      if (i_compare_valid && (i_compare_ch == CH_BITS'(n))) cmp_stg_d[n] = i_compare;
    end

`ifdef PWM_MULTI_CENTER_EN
    mode_stg_d = mode_stg_q;
    mode_act_d = mode_act_q;
    state_d    = state_q;
    if (i_top_valid) mode_stg_d = i_mode;

    if (top_act_q == '0) begin
      reload  = 1'b1;
      cnt_d   = '0;
      state_d = ST_UP;
    end else if (mode_act_q) begin
      if (state_q == ST_UP) begin
        if (cnt_q < top_act_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = ST_DOWN;
          cnt_d   = top_act_q - 1'b1;
        end
      end else begin
        if (cnt_q > RESOLUTION'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          reload  = 1'b1;
          state_d = ST_UP;
          cnt_d   = '0;
        end
      end
    end else begin
      state_d = ST_UP;
      if (cnt_q >= top_act_q) begin
        reload = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (reload) mode_act_d = mode_stg_d;
`else
    // top == 0 falls out naturally: counter 0 >= top reloads every cycle.
    if (cnt_q >= top_act_q) begin
      reload = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif

    if (reload) begin
      top_act_d = top_stg_d;
      cmp_act_d = cmp_stg_d;
    end
    cyc_end_d = reload;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      top_stg_q <= '0;
      top_act_q <= '0;
      cyc_end_q <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        cmp_stg_q[n] <= '0;
        cmp_act_q[n] <= '0;
      end
`ifdef PWM_MULTI_CENTER_EN
      state_q    <= ST_UP;
      mode_stg_q <= 1'b0;
      mode_act_q <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      top_stg_q <= top_stg_d;
      top_act_q <= top_act_d;
      cyc_end_q <= cyc_end_d;
      for (int n = 0; n < CHANNELS; n++) begin
        cmp_stg_q[n] <= cmp_stg_d[n];
        cmp_act_q[n] <= cmp_act_d[n];
      end
`ifdef PWM_MULTI_CENTER_EN
      state_q    <= state_d;
      mode_stg_q <= mode_stg_d;
      mode_act_q <= mode_act_d;
`endif
    end
  end

  // Comparison is RESOLUTION+1 bits so a compare of top+1 (or more) is 100 %.
  always_comb begin
    o_pwm = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      o_pwm[n] = ({1'b0, cnt_q} < cmp_act_q[n]);
    end
  end

  assign o_cycle_end = cyc_end_q;
`ifdef PWM_MULTI_CENTER_EN
  assign o_dir_down = (state_q == ST_DOWN);
`else
  assign o_dir_down = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed bench for pwm_multi (RESOLUTION=8, CHANNELS=5).
// Each observed sample is the vector {o_dir_down, o_cycle_end, o_pwm}.
// Expected samples come from a small counter model fed by exp_cmp and are
// pushed into exp_q, then compared cycle by cycle.
module tb_pwm_multi;
  localparam int R   = 8;
  localparam int CH  = 5;
  localparam int CHB = 3;

  logic          clk;
  logic          rst;
  logic [R-1:0]  i_top;
  logic          i_mode;
  logic          i_top_valid;
  logic [R:0]    i_compare;
  logic [CHB-1:0] i_compare_ch;
  logic          i_compare_valid;
  logic [CH-1:0] o_pwm;
  logic          o_cycle_end;
  logic          o_dir_down;

  int total;
  int bad;
  int exp_cmp [CH];
  logic [6:0] exp_q [$];

  pwm_multi #(.RESOLUTION(R), .CHANNELS(CH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_top          (i_top),
    .i_mode         (i_mode),
    .i_top_valid    (i_top_valid),
    .i_compare      (i_compare),
    .i_compare_ch   (i_compare_ch),
    .i_compare_valid(i_compare_valid),
    .o_pwm          (o_pwm),
    .o_cycle_end    (o_cycle_end),
    .o_dir_down     (o_dir_down)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit tv, input int top, input bit mode,
                    input bit cv, input int ch, input int cmp);
    i_top_valid     = tv;
    i_top           = R'(top);
    i_mode          = mode;
    i_compare_valid = cv;
    i_compare_ch    = CHB'(ch);
    i_compare       = (R+1)'(cmp);
    cyc();
    i_top_valid     = 1'b0;
    i_compare_valid = 1'b0;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model(input int c, input bit ce, input bit dn);
    logic [6:0] v;
    v = '0;
    v[6] = dn;
    v[5] = ce;
    for (int n = 0; n < CH; n++) v[n] = (c < exp_cmp[n]);
    return v;
  endfunction

  task automatic push_edge(input int from, input int to);
    for (int c = from; c <= to; c++) exp_q.push_back(model(c, (c == 0), 1'b0));
  endtask

  task automatic push_center(input int top);
    for (int c = 0; c <= top; c++) exp_q.push_back(model(c, (c == 0), 1'b0));
    for (int c = top - 1; c >= 1; c--) exp_q.push_back(model(c, 1'b0, 1'b1));
  endtask

  // Compares the current sample first; advances between entries only.
  task automatic drain(input string tag);
    logic [6:0] v;
    while (exp_q.size() != 0) begin
      v = exp_q.pop_front();
      chk(tag, {25'd0, o_dir_down, o_cycle_end, o_pwm}, {25'd0, v});
      if (exp_q.size() != 0) cyc();
    end
  endtask

  task automatic wait_ce(input int lim);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while ((o_cycle_end !== 1'b1) && (k < lim));
    chk("wait_ce", {31'd0, o_cycle_end}, 32'd1);
  endtask

  function automatic logic [31:0] obs_vec();
    return {25'd0, o_dir_down, o_cycle_end, o_pwm};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    for (int n = 0; n < CH; n++) exp_cmp[n] = 0;
    rst = 1'b1;
    i_top = '0; i_mode = 1'b0; i_top_valid = 1'b0;
    i_compare = '0; i_compare_ch = '0; i_compare_valid = 1'b0;

    // reset, with strobes that must be ignored
    wr(1'b1, 5, 1'b0, 1'b1, 0, 7);
    cyc();
    cyc();
    chk("reset_out", obs_vec(), 32'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("after_release", obs_vec(), 32'h20);
    end

    // edge, top=9, ch0=3 (write coincides with top==0 reload)
    wr(1'b1, 9, 1'b0, 1'b1, 0, 3);
    exp_cmp[0] = 3;
    push_edge(0, 9);
    push_edge(0, 9);
    drain("edge_top9");

    // top=255, ch1=0 applied at this reload; ch2=256 staged mid-period
    wr(1'b1, 255, 1'b0, 1'b1, 1, 0);
    wr(1'b0, 0, 1'b0, 1'b1, 2, 256);
    chk("staged_not_active", {31'd0, o_pwm[2]}, 32'd0);
    wait_ce(300);
    exp_cmp[2] = 256;
    push_edge(0, 255);
    push_edge(0, 255);
    drain("full_and_zero");

    // top=9 and ch3=5 written on the reload edge: immediate
    wr(1'b1, 9, 1'b0, 1'b1, 3, 5);
    exp_cmp[3] = 5;
    push_edge(0, 3);
    drain("ch3_5_immediate");
    // ch3=7 written mid-period: old duty until reload
    wr(1'b0, 0, 1'b0, 1'b1, 3, 7);
    push_edge(4, 9);
    drain("ch3_hold_old");
    cyc();
    exp_cmp[3] = 7;
    push_edge(0, 9);
    drain("ch3_7_new");

    // out-of-range channel writes, one on the reload edge
    wr(1'b0, 0, 1'b0, 1'b1, 5, 200);
    wr(1'b0, 0, 1'b0, 1'b1, 7, 1);
    push_edge(1, 9);
    drain("bad_ch_same");
    cyc();
    push_edge(0, 9);
    drain("bad_ch_next");

    // reset mid-period with a pending staged write
    cyc();
    wr(1'b0, 0, 1'b0, 1'b1, 4, 9);
    cyc();
    chk("pre_reset", obs_vec(), {25'd0, model(2, 1'b0, 1'b0)});
    rst = 1'b1;
    cyc();
    chk("mid_reset", obs_vec(), 32'h00);
    rst = 1'b0;
    for (int n = 0; n < CH; n++) exp_cmp[n] = 0;
    cyc();
    chk("post_reset_a", obs_vec(), 32'h20);
    cyc();
    chk("post_reset_b", obs_vec(), 32'h20);

    // mode=1, top=8, ch0=2
    wr(1'b1, 8, 1'b1, 1'b1, 0, 2);
    exp_cmp[0] = 2;
`ifdef PWM_MULTI_CENTER_EN
    push_center(8);
    push_center(8);
    drain("center_top8");
`else
    push_edge(0, 8);
    push_edge(0, 8);
    drain("mode_ignored_top8");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
